// File: rtl/systolic_conv2d_engine_if.sv
// Operand/result bundle between the conv operand register file, the systolic engine and the result collector.
interface systolic_conv2d_engine_if #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int IMG    = 4,
   parameter int RES_W  = 8
);
   localparam int OUT = IMG - K + 1;

   logic                          start;
   logic                          flip;
   logic [IMG*IMG*DATA_W-1:0]     img;
   logic [K*K*DATA_W-1:0]         krn;
   logic                          busy;
   logic                          done;
   logic                          res_valid;
   logic [OUT*OUT*RES_W-1:0]      res;

   modport master (
      output start, flip, img, krn,
      input  busy, done, res_valid, res
   );

   modport slave (
      input  start, flip, img, krn,
      output busy, done, res_valid, res
   );
endinterface

// File: rtl/systolic_conv2d_engine.sv
// Output-stationary systolic valid-mode 2-D convolution/correlation, one MAC PE per output pixel.
// Optional SYSTOLIC_SAT_EN: saturate results to RES_W instead of wrapping modulo 2^RES_W.
module systolic_conv2d_engine #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int IMG    = 4,
   parameter int RES_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   systolic_conv2d_engine_if.slave bus
);
   localparam int OUT     = IMG - K + 1;
   localparam int KK      = K * K;
   localparam int ACC_W   = 2*DATA_W + ((KK > 1) ? $clog2(KK) : 1);
   localparam int D       = 2*(OUT-1);
   localparam int RUN_LEN = KK + D;
   localparam int CNT_W   = $clog2(RUN_LEN + 1);
   localparam int KY_W    = (K > 1) ? $clog2(K) : 1;
   localparam int IDX_W   = (IMG*IMG > 1) ? $clog2(IMG*IMG) : 1;
   localparam int KIDX_W  = (KK > 1) ? $clog2(KK) : 1;
   localparam int SK_N    = (D > 0) ? D : 1;
   localparam int WW      = (ACC_W > RES_W) ? ACC_W : RES_W;

   if (IMG < K) begin : g_bad_cfg
      $error("systolic_conv2d_engine: IMG must be >= K");
   end

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   // A step tag travels down the anti-diagonals: PE(r,c) consumes the tag sitting at skew depth r+c.
   typedef struct packed {
      logic              vld;
      logic [KY_W-1:0]   ky;
      logic [KY_W-1:0]   kx;
      logic [DATA_W-1:0] b;
   } tag_t;

   state_t            state, next_state;
   logic [DATA_W-1:0] img_q [IMG*IMG];
   logic [DATA_W-1:0] krn_q [KK];
   logic              flip_q;
   logic [CNT_W-1:0]  run_cnt;
   logic [KY_W-1:0]   ky_cnt, kx_cnt;
   tag_t              tag0;
   tag_t              sk [SK_N];
   tag_t              tg [D+1];
   logic [ACC_W-1:0]  acc      [OUT][OUT];
   logic [ACC_W-1:0]  acc_next [OUT][OUT];
   logic [RES_W-1:0]  res_q    [OUT][OUT];
   logic              res_valid_q;
   logic              accept;
   logic              run_last;

   function automatic logic [RES_W-1:0] shape(input logic [ACC_W-1:0] v);
      logic [WW-1:0] w;
      w = WW'(v);
`ifdef SYSTOLIC_SAT_EN
      if (w > WW'({RES_W{1'b1}})) return '1;
`endif
      return w[RES_W-1:0];
   endfunction

   assign accept   = bus.start && (state == IDLE || state == DONE);
   assign run_last = (state == RUN) && (run_cnt == CNT_W'(RUN_LEN-1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = LOAD;
         LOAD:    next_state = RUN;
         RUN:     if (run_last) next_state = DONE;
         DONE:    next_state = bus.start ? LOAD : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   // Operands are captured on the accepting edge so input changes during LOAD/RUN are invisible.
   always_ff @(posedge clk) begin
      if (rst) begin
         flip_q <= 1'b0;
         for (int i = 0; i < IMG*IMG; i++) img_q[i] <= '0;
         for (int i = 0; i < KK; i++)      krn_q[i] <= '0;
      end else if (accept) begin
         flip_q <= bus.flip;
         for (int i = 0; i < IMG*IMG; i++) img_q[i] <= bus.img[i*DATA_W +: DATA_W];
         for (int i = 0; i < KK; i++)      krn_q[i] <= bus.krn[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || state == LOAD) begin
         run_cnt <= '0;
         ky_cnt  <= '0;
         kx_cnt  <= '0;
      end else if (state == RUN) begin
         run_cnt <= run_cnt + CNT_W'(1);
         if (kx_cnt == KY_W'(K-1)) begin
            kx_cnt <= '0;
            ky_cnt <= ky_cnt + KY_W'(1);
         end else begin
            kx_cnt <= kx_cnt + KY_W'(1);
         end
      end
   end

   // Flipped kernel index (K-1-ky)*K + (K-1-kx) collapses to KK-1-s.
   always_comb begin
      tag0 = '0;
      if (state == RUN && run_cnt < CNT_W'(KK)) begin
         tag0.vld = 1'b1;
         tag0.ky  = ky_cnt;
         tag0.kx  = kx_cnt;
         tag0.b   = krn_q[flip_q ? (KIDX_W'(KK-1) - KIDX_W'(run_cnt)) : KIDX_W'(run_cnt)];
      end
      tg[0] = tag0;
      for (int d = 1; d <= D; d++) tg[d] = sk[d-1];
   end

   always_ff @(posedge clk) begin
      if (rst || state == LOAD) begin
         for (int i = 0; i < SK_N; i++) sk[i] <= '0;
      end else begin
         sk[0] <= tag0;
         for (int i = 1; i < SK_N; i++) sk[i] <= sk[i-1];
      end
   end

   always_comb begin : pe_math
      tag_t              pe_tag;
      logic [IDX_W-1:0]  ia;
      logic [2*DATA_W-1:0] prod;
      pe_tag = '0;
      ia     = '0;
      prod   = '0;
      for (int r = 0; r < OUT; r++) begin
         for (int c = 0; c < OUT; c++) begin
            pe_tag = tg[r+c];
            ia     = IDX_W'((r + int'(pe_tag.ky)) * IMG + c + int'(pe_tag.kx));
            prod   = {{DATA_W{1'b0}}, img_q[ia]} * {{DATA_W{1'b0}}, pe_tag.b};
            acc_next[r][c] = pe_tag.vld ? acc[r][c] + ACC_W'(prod) : acc[r][c];
         end
      end
   end

   // Results are taken from acc_next so the final MAC of the last PE lands in res on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         for (int r = 0; r < OUT; r++) begin
            for (int c = 0; c < OUT; c++) begin
               acc[r][c]   <= '0;
               res_q[r][c] <= '0;
            end
         end
      end else begin
         if (accept)        res_valid_q <= 1'b0;
         else if (run_last) res_valid_q <= 1'b1;
         for (int r = 0; r < OUT; r++) begin
            for (int c = 0; c < OUT; c++) begin
               if (state == LOAD)     acc[r][c] <= '0;
               else if (state == RUN) acc[r][c] <= acc_next[r][c];
               if (run_last) res_q[r][c] <= shape(acc_next[r][c]);
            end
         end
      end
   end

   always_comb begin
      bus.res = '0;
      for (int r = 0; r < OUT; r++) begin
         for (int c = 0; c < OUT; c++) begin
            bus.res[(r*OUT+c)*RES_W +: RES_W] = res_q[r][c];
         end
      end
      bus.res_valid = res_valid_q;
   end
endmodule
